// File: rtl/multiply_result_unit.sv
// Multi-cycle mult/div execution with architectural HI/LO store and mthi/mtlo writes.
// Optional MDU_DIVZERO_HOLD_EN: divide by zero leaves HI/LO unchanged at commit.
module multiply_result_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  ctrl,
  input  logic        start,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      stage_hi;
  logic [31:0]      stage_lo;
  logic             stage_hold;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_hold;

  // Result computed from the operands presented at the launch edge; signed
  // divide works on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    res_hold = 1'b0;
    prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u   = {32'b0, A} * {32'b0, B};
    neg_a    = ~ctrl[0] & A[31];
    neg_b    = ~ctrl[0] & B[31];
    mag_a    = neg_a ? -A : A;
    mag_b    = neg_b ? -B : B;
    q_u      = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    r_u      = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    case (ctrl)
      2'b00:   {res_hi, res_lo} = prod_s;
      2'b01:   {res_hi, res_lo} = prod_u;
      default: begin
        if (B == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          res_hold = 1'b1;
`else
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
`endif
        end else begin
          res_lo = (neg_a ^ neg_b) ? -q_u : q_u;
          res_hi = neg_a ? -r_u : r_u;
        end
      end
    endcase
  end

  // Control FSM, latency counter and HI/LO register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      HI         <= '0;
      LO         <= '0;
      stage_hi   <= '0;
      stage_lo   <= '0;
      stage_hold <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) HI <= wdata;
          if (lo_we) LO <= wdata;
          if (start) begin
            stage_hi   <= res_hi;
            stage_lo   <= res_lo;
            stage_hold <= res_hold;
            cnt        <= ctrl[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            if (!stage_hold) begin
              HI <= stage_hi;
              LO <= stage_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_result_unit.sv
// Self-checking bench for multiply_result_unit: directed plan cases plus randomized ops
// against an arithmetic reference model (honours MDU_DIVZERO_HOLD_EN).
module tb_multiply_result_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ctrl;
  logic        start;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors;
  int miscompares;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  multiply_result_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ctrl(ctrl), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       output logic [31:0] rh, output logic [31:0] rl, output logic hold);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    hold = 1'b0;
    rh   = '0;
    rl   = '0;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = longint'(sa * sb);
        rh = up[63:32];
        rl = up[31:0];
      end
      2'b01: begin
        up = longint'(a) * longint'(b);
        rh = up[63:32];
        rl = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          hold = 1'b1;
`else
          rh = a;
          rl = 32'hFFFF_FFFF;
`endif
        end else if (op == 2'b10) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          sq = sa / sb;
          sr = sa % sb;
          rl = sq[31:0];
          rh = sr[31:0];
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endtask

  // Launch one op at the next edge and follow it to completion; leaves the
  // bench in the done cycle so a following call launches back-to-back.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input bit disturb, input bit wr_same);
    logic [31:0] rh, rl, wd;
    logic        hold;
    int          n;
    n = op[1] ? DIV_N : MULT_N;
    model(a, b, op, rh, rl, hold);
    wd = $urandom;
    A = a; B = b; ctrl = op; start = 1'b1;
    hi_we = wr_same; lo_we = wr_same; wdata = wd;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (wr_same) begin
      exp_hi = wd;
      exp_lo = wd;
    end
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("busy_run%0d", i), {31'b0, busy}, 32'd1);
      chk($sformatf("done_run%0d", i), {31'b0, done}, 32'd0);
      chk($sformatf("hi_run%0d", i), HI, exp_hi);
      chk($sformatf("lo_run%0d", i), LO, exp_lo);
      if (disturb && i == 1) begin
        A = ~a; B = b + 32'd1; ctrl = op ^ 2'b01;
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = ~wd;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      step();
    end
    if (!hold) begin
      exp_hi = rh;
      exp_lo = rl;
    end
    chk("busy_end", {31'b0, busy}, 32'd0);
    chk("done_end", {31'b0, done}, 32'd1);
    chk("hi_commit", HI, exp_hi);
    chk("lo_commit", LO, exp_lo);
  endtask

  task automatic write_direct(input bit hw, input bit lw, input logic [31:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) exp_hi = d;
    if (lw) exp_lo = d;
    chk("hi_direct", HI, exp_hi);
    chk("lo_direct", LO, exp_lo);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("done_idle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          sel;
    vectors = 0; miscompares = 0;
    exp_hi = '0; exp_lo = '0;
    reset = 1'b1; A = '0; B = '0; ctrl = '0; start = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    step();

    run_op(32'hFFFF_FFFE, 32'd3, 2'b00, 1'b0, 1'b0);
    chk("mult_hi_lit", HI, 32'hFFFF_FFFF);
    chk("mult_lo_lit", LO, 32'hFFFF_FFFA);
    step();
    chk("done_drop", {31'b0, done}, 32'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0);
    chk("multu_hi_lit", HI, 32'hFFFF_FFFE);
    chk("multu_lo_lit", LO, 32'h0000_0001);

    // div then divu back-to-back from the commit cycle
    run_op(32'hFFFF_FFF9, 32'd2, 2'b10, 1'b0, 1'b0);
    chk("div_lo_lit", LO, 32'hFFFF_FFFD);
    chk("div_hi_lit", HI, 32'hFFFF_FFFF);
    run_op(32'd7, 32'd2, 2'b11, 1'b0, 1'b0);
    chk("divu_lo_lit", LO, 32'd3);
    chk("divu_hi_lit", HI, 32'd1);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b0);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);
    step();

    write_direct(1'b1, 1'b0, 32'h0000_1234);
    write_direct(1'b1, 1'b1, 32'hCAFE_F00D);
    run_op(32'd100, 32'd7, 2'b00, 1'b1, 1'b0);
    run_op(32'd9, 32'd4, 2'b01, 1'b0, 1'b1);
    step();

    write_direct(1'b1, 1'b0, 32'hAA);
    write_direct(1'b0, 1'b1, 32'hBB);
    run_op(32'h55, 32'd0, 2'b11, 1'b0, 1'b0);
`ifdef MDU_DIVZERO_HOLD_EN
    chk("dz_hold_hi", HI, 32'hAA);
    chk("dz_hold_lo", LO, 32'hBB);
`else
    chk("dz_hi", HI, 32'h55);
    chk("dz_lo", LO, 32'hFFFF_FFFF);
`endif
    step();

    // Reset while a divide is in flight (cycle k+3)
    A = 32'd1000; B = 32'd3; ctrl = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    exp_hi = '0; exp_lo = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_done", {31'b0, done}, 32'd0);
      chk("post_rst_hi", HI, 32'd0);
    end
    run_op(32'd1000, 32'd3, 2'b10, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = ra & 32'hFF; rb = rb & 32'hF; end
      if ($urandom_range(0, 3) == 0)
        write_direct(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(ra, rb, rop, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
